// File: rtl/ps2_hit_encoder.sv
// ps2_hit_encoder: PS/2 frame receiver that turns presses of keys 1-5 into one-shot mole-hit codes.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_hit_encoder #(
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    input  logic       enable,
    output logic [2:0] hitCode,
    output logic       frameError
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev, fall, din, timeout, edge_ok;
    logic [WW-1:0] wd;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          par_ok, byte_ok, byte_bad;
    logic          brk_pend, ext_pend, brk_byte, ext_byte;
    logic [4:0]    held_mask, key_oh;
    logic [2:0]    key_code;
    logic          hit_req;
    logic [HW-1:0] hold;

    assign fall    = clk_prev & ~clk_sync[1];
    assign din     = data_sync[1];
    assign timeout = (state != IDLE) && (wd == WW'(TIMEOUT_CYCLES));
    assign edge_ok = fall & ~timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2Clk};
            data_sync <= {data_sync[0], ps2Data};
            clk_prev  <= clk_sync[1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (timeout)
            state_n = IDLE;
        else if (fall)
            case (state)
                IDLE:    state_n = din ? IDLE : DATA;
                DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_n = STOP;
                default: state_n = IDLE;
            endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd      <= '0;
            shift   <= '0;
            bit_cnt <= '0;
        end else begin
            wd <= (state == IDLE || fall) ? '0 : wd + WW'(1);
            if (edge_ok && state == IDLE)
                bit_cnt <= '0;
            if (edge_ok && state == DATA) begin
                shift   <= {din, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par;
    always_ff @(posedge clock) begin
        if (reset)
            par <= 1'b0;
        else if (edge_ok && state == PARITY)
            par <= din;
    end
    assign par_ok = ^{shift, par};
`else
    assign par_ok = 1'b1;
`endif

    assign byte_ok  = edge_ok && state == STOP && din && par_ok;
    assign byte_bad = edge_ok && state == STOP && !(din && par_ok);

    always_ff @(posedge clock) begin
        if (reset) frameError <= 1'b0;
        else       frameError <= timeout | byte_bad;
    end

    assign brk_byte = shift == 8'hF0;
    assign ext_byte = shift == 8'hE0;
    assign key_oh   = {shift == 8'h2E, shift == 8'h25, shift == 8'h26, shift == 8'h1E, shift == 8'h16};
    assign key_code = key_oh[0] ? 3'd1 : key_oh[1] ? 3'd2 : key_oh[2] ? 3'd3 :
                      key_oh[3] ? 3'd4 : key_oh[4] ? 3'd5 : 3'd0;
    // A make only scores when its key was released since the last make (no auto-repeat hits).
    assign hit_req  = byte_ok && !brk_byte && !ext_byte && !ext_pend && !brk_pend &&
                      (|key_oh) && !(|(held_mask & key_oh));

    always_ff @(posedge clock) begin
        if (reset) begin
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
            held_mask <= '0;
        end else if (byte_ok) begin
            brk_pend <= brk_byte | (ext_byte & brk_pend);
            ext_pend <= ext_byte | (brk_byte & ext_pend);
            if (!brk_byte && !ext_byte && !ext_pend)
                held_mask <= brk_pend ? (held_mask & ~key_oh) : (held_mask | key_oh);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hitCode <= 3'd0;
            hold    <= '0;
        end else if (hit_req && enable) begin
            hitCode <= key_code;
            hold    <= HW'(HOLD_CYCLES);
        end else if (!enable) begin
            hitCode <= 3'd0;
            hold    <= '0;
        end else if (hold != '0) begin
            hold <= hold - HW'(1);
            if (hold == HW'(1))
                hitCode <= 3'd0;
        end
    end
endmodule

// File: doc/ps2_hit_encoder.md
# ps2_hit_encoder

Receives PS/2 keyboard frames and turns presses of keys 1–5 into the 3-bit mole-hit code consumed by the game datapath's `userGameInput`. Codes are 000 for no hit and 001–101 for moles 1–5. The block sits between the board's PS/2 pins and the main game FSM. Its responsibilities:
- synchronise the PS/2 lines;
- assemble and check 11-bit frames;
- track make/break state per key;
- emit a one-shot hit code per physical press, so keyboard auto-repeat never scores twice.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1: number of clock cycles a non-zero `hitCode` is held. Minimum 1.
- `TIMEOUT_CYCLES`, default 50000: idle clock cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.

Ports:
- `clock` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `ps2Clk` in 1: raw PS/2 clock pin. Asynchronous; idles high.
- `ps2Data` in 1: raw PS/2 data pin. Asynchronous; idles high.
- `enable` in 1: hit-emission gate; the game drives it high only during INGAME. Decoding continues while it is low.
- `hitCode` out 3: 000 = none; 001–101 = mole 1–5. Same encoding as `userGameInput`.
- `frameError` out 1: one-cycle pulse when a frame is discarded.

## Operation
- Input conditioning:
  - Two-flop synchroniser on each of `ps2Clk` and `ps2Data`; both reset to 1.
  - Falling-edge detect on synchronised `ps2Clk`: previous sample 1, current sample 0.
  - All sampling of data happens on detected falling edges only.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 (start bit), go to DATA and clear the bit counter. An edge with data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift data bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: check the frame.
    - Stop bit must be 1 and parity must be odd over data+parity bit.
    - Pass: the byte is accepted.
    - Fail: the byte is discarded and `frameError` pulses.
    - Either way, return to IDLE.
- Watchdog:
  - The counter clears on every detected edge and in IDLE.
  - If it reaches `TIMEOUT_CYCLES` in any non-IDLE state: FSM returns to IDLE, `frameError` pulses, and partial data is dropped.
- Byte interpretation, in this priority order:
  1. 0xF0 sets `breakPending`.
  2. 0xE0 sets `extPending`.
  3. Otherwise, the byte is a key code and both pending flags clear after it.
- Key map: 0x16→1, 0x1E→2, 0x26→3, 0x25→4, 0x2E→5. Any other code is ignored.
  - Extended codes (`extPending`=1) are ignored for mapping.
  - This includes extended breaks: both flags clear, and `heldMask` is unchanged.
- Held tracking via `heldMask[4:0]`:
  - A break of key n clears bit n.
  - A make of key n with bit n clear sets bit n and requests a hit n.
  - A make of key n with bit n already set (auto-repeat) produces nothing.
- Hit emission:
  - A requested hit with `enable`=1 loads `hitCode` = n and the hold counter = `HOLD_CYCLES`.
  - `hitCode` returns to 000 when the hold counter expires.
  - A new hit during a hold overrides the code and restarts the hold.
  - `enable`=0 forces `hitCode` to 000 on the next edge. `heldMask` still updates.

## Timing
- Reset values:
  - Outputs: `hitCode`=000, `frameError`=0.
  - Internal: FSM=IDLE, `heldMask`=0, pending flags=0, shift register, bit counter, watchdog and hold counter all 0, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame silently: no `frameError` pulse.
- Latency: synchronised edge detection lags the pin by 3 cycles. Per frame:
  - `frameError` (parity/stop failure) pulses in the cycle after the STOP-state edge is detected.
  - `hitCode` becomes valid in that same cycle.
- `hitCode` is non-zero for exactly `HOLD_CYCLES` consecutive cycles, unless `enable` drops or `reset` asserts first.
- A watchdog `frameError` pulses in the cycle after the count reaches `TIMEOUT_CYCLES`.
- `frameError` is never asserted for two consecutive cycles.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: odd-parity failure discards the byte and pulses `frameError`.
  - Undefined: the parity bit is clocked in and ignored; only a bad stop bit or a timeout raises `frameError`.

## Test plan
Bench settings: PS/2 clock half-period 10 cycles, `HOLD_CYCLES`=4, `TIMEOUT_CYCLES`=100, `PS2_PARITY_CHECK_EN` defined.
- Valid frame 0x16, `enable`=1 → `hitCode`=001 for exactly 4 cycles, then 000; `frameError` stays 0.
- Auto-repeat and re-press:
  - 0x2E, 0x2E → a single 101 burst.
  - Then F0, 2E, 2E → a second 101 burst, only after the final make.
- Parity errors:
  - 0x1E with even parity → no hit and one 1-cycle `frameError`.
  - A following valid 0x1E → 010.
- Watchdog:
  - Stall `ps2Clk` high after 4 data bits for 150 cycles → `frameError` pulse and FSM back in IDLE.
  - Next valid 0x26 → 011.
- `enable` gating:
  - `enable`=0, send 0x25 → `hitCode` stays 000.
  - Set `enable`=1, repeat 0x25 → still 000, because the key is held.
  - F0 25 then 25 → 100.
- Extended codes and reset:
  - E0 16 → no hit, `heldMask` unchanged.
  - `reset` pulsed mid-frame → `hitCode`=000, `frameError`=0.
  - Next full 0x16 frame → 001.
